m68k_bus_decoder: RTL and testbench
===================================

Name: m68k_bus_decoder

Overview:
- Parametrised, registered successor to the combinational 68K chip-select decoder.
- Decodes up to NUM_REGIONS runtime-programmable address windows. Emits registered one-hot chip selects and owns the 68K bus-cycle handshake.
- Handshake features: per-region wait states, optional external ready, read/write qualification, DTACK generation, and a bus-error timeout for unmapped or stuck cycles.
- Sits between the 68K core and all memory/IO selects on every Alpha68k PCB variant. The per-PCB tables are driven from the top level.

Parameters:
- NUM_REGIONS, 16: number of decode windows (1..32).
- ADDR_W, 24: address width compared.
- WAIT_W, 4: width of per-region wait-state count.
- TIMEOUT, 255: cycles in WAIT/MISS before bus error (only with M68K_BUS_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m68k_a  in  ADDR_W  68K byte address (A0 derived from UDS/LDS upstream).
- m68k_as_n  in  1  address strobe, active low.
- m68k_rw  in  1  1 = read, 0 = write.
- region_en  in  NUM_REGIONS  per-window enable.
- region_base  in  NUM_REGIONS*ADDR_W  window base; slice i = window i.
- region_mask  in  NUM_REGIONS*ADDR_W  compare mask; 1 = bit compared.
- region_mode  in  2*NUM_REGIONS  00 any, 01 read-only, 10 write-only, 11 disabled.
- region_wait  in  NUM_REGIONS*WAIT_W  wait states before DTACK.
- region_ext  in  NUM_REGIONS  1 = also wait for ext_rdy.
- ext_rdy  in  1  external ready (e.g. SDRAM/ROM loader).
- cs  out  NUM_REGIONS  registered one-hot chip selects.
- cs_idx  out  5  index of the active window (valid while any cs bit is set).
- dtack_n  out  1  data acknowledge, active low.
- berr_n  out  1  bus error, active low.
- miss  out  1  one-cycle pulse when a strobed address hits no window.

Behaviour:
- Reset values: cs = 0, cs_idx = 0, dtack_n = 1, berr_n = 1, miss = 0, state IDLE, counters 0, armed = 0.
- Hit for window i: region_en[i] & ((m68k_a ^ base_i) & mask_i) == 0 & mode permits m68k_rw.
- Priority: the lowest hit index wins; at most one cs bit is ever set.
- armed is set in any cycle with m68k_as_n = 1. A cycle starts only when armed. This prevents decoding a strobe already low when reset released.
- States: IDLE, WAIT, MISS, ACK, TERM.
- IDLE:
  - Leave only when m68k_as_n = 0 and armed; clear armed.
  - On a hit, go to WAIT: cs[i] set, cs_idx = i, wait counter = region_wait_i, all registered next clock.
  - On no hit, go to MISS with a miss pulse.
- WAIT:
  - Counter decrements each clock while nonzero.
  - When the counter = 0 and (ext_rdy | !region_ext_i), go to ACK; dtack_n goes low the next clock.
  - Latency from the IDLE sample to dtack_n low is 2 + wait clocks.
- ACK: hold dtack_n = 0 and cs until m68k_as_n = 1. Then, on the same edge, return to IDLE with cs = 0 and dtack_n = 1.
- Abort: m68k_as_n = 1 in WAIT or MISS returns to IDLE next clock, with cs cleared and no dtack or berr.
- Address or rw changes mid-cycle are ignored; the decode is latched at IDLE exit.
- Back-to-back cycles: a new cycle requires one sampled m68k_as_n = 1 clock between cycles.
- Reset mid-cycle: all outputs return to their reset values next clock, and the next cycle needs a fresh strobe high.
- The wait counter saturates at 0; there is no wrap.

Optional Feature:
- M68K_BUS_TIMEOUT_EN defined:
  - An 8+ bit timeout counter runs in WAIT and MISS.
  - On reaching TIMEOUT, go to TERM: berr_n = 0, cs = 0, dtack_n = 1, held until m68k_as_n = 1, then IDLE.
  - A timeout takes precedence over ext_rdy arriving on the same clock.
- Not defined:
  - berr_n is tied to 1.
  - MISS auto-acknowledges like a zero-wait window: dtack_n low 2 clocks after the sample, no cs.
  - WAIT with region_ext waits on ext_rdy indefinitely.

Test Plan:
- Window 0 base 0x000000 mask 0xFC0000 wait 0; read at 0x012344 -> cs = 0x0001 one clock after the AS sample, dtack_n low at +2, both released one clock after AS rises.
- Windows 3 and 5 overlapping at 0x100000, wait_3 = 3 -> cs[3] only, cs_idx = 3, dtack_n low at +5.
- Window mode 01 at 0x080000; write there -> miss pulse, no cs. With the timeout macro: berr_n low 255 clocks later. Without it: dtack_n low at +2.
- region_ext = 1, ext_rdy held low 10 clocks then high -> dtack_n low on the clock after ext_rdy is sampled high. AS raised early in another run -> IDLE, no dtack.
- reset asserted in ACK with AS still low -> next clock cs = 0, dtack_n = 1; no new cycle until AS is seen high then low again.
- Back-to-back reads with a single high clock of AS between them -> two complete handshakes, cs never stuck or doubled.

Source files
------------

// File: rtl/m68k_bus_decoder.sv
// Registered 68K chip-select decoder with DTACK handshake, wait states and ext_rdy.
// Optional bus-error timeout enabled by defining M68K_BUS_TIMEOUT_EN.
module m68k_bus_decoder #(
    parameter int NUM_REGIONS = 16,
    parameter int ADDR_W      = 24,
    parameter int WAIT_W      = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             m68k_a,
    input  logic                          m68k_as_n,
    input  logic                          m68k_rw,
    input  logic [NUM_REGIONS-1:0]        region_en,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_base,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_mask,
    input  logic [2*NUM_REGIONS-1:0]      region_mode,
    input  logic [NUM_REGIONS*WAIT_W-1:0] region_wait,
    input  logic [NUM_REGIONS-1:0]        region_ext,
    input  logic                          ext_rdy,
    output logic [NUM_REGIONS-1:0]        cs,
    output logic [4:0]                    cs_idx,
    output logic                          dtack_n,
    output logic                          berr_n,
    output logic                          miss
);

    if (NUM_REGIONS < 1 || NUM_REGIONS > 32 || TIMEOUT < 1) begin : g_bad_param
        $error("m68k_bus_decoder: NUM_REGIONS must be 1..32 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_MISS, S_ACK, S_TERM} state_t;

    state_t                   state, state_d;
    logic                     armed, armed_d;
    logic [WAIT_W-1:0]        wcnt, wcnt_d;
    logic                     ext_sel, ext_d;
    logic [NUM_REGIONS-1:0]   cs_d;
    logic [4:0]               cs_idx_d;
    logic                     dtack_d, berr_d, miss_d;

    logic                     any_hit, hit_ext, rw_ok;
    logic [4:0]               hit_idx;
    logic [NUM_REGIONS-1:0]   hit_cs;
    logic [WAIT_W-1:0]        hit_wait;
    logic [1:0]               mode_i;
    logic                     timed_out;

`ifdef M68K_BUS_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [TO_W-1:0] tcnt, tcnt_d;
    assign timed_out = (tcnt == TO_W'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    // Lowest enabled, rw-permitted window whose masked address matches wins.
    always_comb begin
        any_hit  = 1'b0;
        hit_idx  = '0;
        hit_cs   = '0;
        hit_wait = '0;
        hit_ext  = 1'b0;
        mode_i   = '0;
        rw_ok    = 1'b0;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            mode_i = region_mode[2*i +: 2];
            rw_ok  = (mode_i == 2'b00) || (mode_i == 2'b01 && m68k_rw) ||
                     (mode_i == 2'b10 && !m68k_rw);
            if (!any_hit && region_en[i] && rw_ok &&
                (((m68k_a ^ region_base[i*ADDR_W +: ADDR_W]) &
                  region_mask[i*ADDR_W +: ADDR_W]) == '0)) begin
                any_hit   = 1'b1;
                hit_idx   = 5'(i);
                hit_cs[i] = 1'b1;
                hit_wait  = region_wait[i*WAIT_W +: WAIT_W];
                hit_ext   = region_ext[i];
            end
        end
    end

    always_comb begin
        state_d  = state;
        armed_d  = armed | m68k_as_n;
        wcnt_d   = wcnt;
        ext_d    = ext_sel;
        cs_d     = cs;
        cs_idx_d = cs_idx;
        dtack_d  = dtack_n;
        berr_d   = berr_n;
        miss_d   = 1'b0;
`ifdef M68K_BUS_TIMEOUT_EN
        tcnt_d   = tcnt;
`endif
        case (state)
            S_IDLE: begin
                if (!m68k_as_n && armed) begin
                    armed_d = 1'b0;
`ifdef M68K_BUS_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                    if (any_hit) begin
                        state_d  = S_WAIT;
                        cs_d     = hit_cs;
                        cs_idx_d = hit_idx;
                        wcnt_d   = hit_wait;
                        ext_d    = hit_ext;
                    end else begin
                        state_d = S_MISS;
                        miss_d  = 1'b1;
                    end
                end
            end
            S_WAIT, S_MISS: begin
                if (m68k_as_n) begin
                    state_d = S_IDLE;
                    cs_d    = '0;
                end else if (timed_out) begin
                    // Timeout beats an ext_rdy arriving on the same clock.
                    state_d = S_TERM;
                    cs_d    = '0;
                    berr_d  = 1'b0;
                end else begin
`ifdef M68K_BUS_TIMEOUT_EN
                    tcnt_d = tcnt + TO_W'(1);
`endif
                    if (state == S_MISS) begin
`ifndef M68K_BUS_TIMEOUT_EN
                        state_d = S_ACK;
                        dtack_d = 1'b0;
`endif
                    end else if (wcnt != '0) begin
                        wcnt_d = wcnt - WAIT_W'(1);
                    end else if (ext_rdy || !ext_sel) begin
                        state_d = S_ACK;
                        dtack_d = 1'b0;
                    end
                end
            end
            S_ACK, S_TERM: begin
                if (m68k_as_n) begin
                    state_d = S_IDLE;
                    cs_d    = '0;
                    dtack_d = 1'b1;
                    berr_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            armed   <= 1'b0;
            wcnt    <= '0;
            ext_sel <= 1'b0;
            cs      <= '0;
            cs_idx  <= '0;
            dtack_n <= 1'b1;
            berr_n  <= 1'b1;
            miss    <= 1'b0;
`ifdef M68K_BUS_TIMEOUT_EN
            tcnt    <= '0;
`endif
        end else begin
            state   <= state_d;
            armed   <= armed_d;
            wcnt    <= wcnt_d;
            ext_sel <= ext_d;
            cs      <= cs_d;
            cs_idx  <= cs_idx_d;
            dtack_n <= dtack_d;
            berr_n  <= berr_d;
            miss    <= miss_d;
`ifdef M68K_BUS_TIMEOUT_EN
            tcnt    <= tcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_m68k_bus_decoder.sv
// Directed bench for m68k_bus_decoder: per-cycle transaction model plus literal checkpoints.
module tb_m68k_bus_decoder;
    localparam int NR = 16;
    localparam int AW = 24;
    localparam int WW = 4;
    localparam int TO = 255;
`ifdef M68K_BUS_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] m68k_a;
    logic          m68k_as_n, m68k_rw, ext_rdy;
    logic [NR-1:0] region_en, region_ext;
    logic [NR*AW-1:0] region_base, region_mask;
    logic [2*NR-1:0]  region_mode;
    logic [NR*WW-1:0] region_wait;
    logic [NR-1:0] cs;
    logic [4:0]    cs_idx;
    logic          dtack_n, berr_n, miss;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    m68k_bus_decoder #(.NUM_REGIONS(NR), .ADDR_W(AW), .WAIT_W(WW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .m68k_a(m68k_a), .m68k_as_n(m68k_as_n),
        .m68k_rw(m68k_rw), .region_en(region_en), .region_base(region_base),
        .region_mask(region_mask), .region_mode(region_mode),
        .region_wait(region_wait), .region_ext(region_ext), .ext_rdy(ext_rdy),
        .cs(cs), .cs_idx(cs_idx), .dtack_n(dtack_n), .berr_n(berr_n), .miss(miss)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int lowest_hit(input logic [AW-1:0] a, input logic rw);
        logic [1:0] md;
        bit ok;
        for (int i = 0; i < NR; i++) begin
            md = region_mode[2*i +: 2];
            ok = (md == 2'b00) || (md == 2'b01 && rw) || (md == 2'b10 && !rw);
            if (region_en[i] && ok &&
                ((a ^ region_base[i*AW +: AW]) & region_mask[i*AW +: AW]) == '0)
                return i;
        end
        return -1;
    endfunction

    // Transaction model: busy/done flags and remaining-wait bookkeeping per bus cycle.
    bit m_busy, m_done, m_armed, m_ext;
    int m_idx, m_left, m_tcnt;
    logic [NR-1:0] e_cs;
    int e_idx;
    bit e_dtack_n, e_berr_n, e_miss;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_armed = 0; m_tcnt = 0;
            e_cs = '0; e_idx = 0; e_dtack_n = 1; e_berr_n = 1; e_miss = 0;
        end else begin
            e_miss = 0;
            if (!m_busy) begin
                if (m68k_as_n) m_armed = 1;
                else if (m_armed) begin
                    m_armed = 0; m_busy = 1; m_done = 0; m_tcnt = 0;
                    m_idx = lowest_hit(m68k_a, m68k_rw);
                    if (m_idx >= 0) begin
                        e_cs   = NR'(1) << m_idx;
                        e_idx  = m_idx;
                        m_left = int'(region_wait[m_idx*WW +: WW]);
                        m_ext  = region_ext[m_idx];
                    end else begin
                        e_miss = 1;
                    end
                end
            end else if (m68k_as_n) begin
                m_armed = 1; m_busy = 0;
                e_cs = '0; e_dtack_n = 1; e_berr_n = 1;
            end else if (!m_done) begin
                m_tcnt++;
                if (TIMEOUT_EN && m_tcnt == TO) begin
                    m_done = 1; e_cs = '0; e_berr_n = 0;
                end else if (m_idx < 0) begin
                    if (!TIMEOUT_EN) begin m_done = 1; e_dtack_n = 0; end
                end else if (m_left > 0) begin
                    m_left--;
                end else if (!m_ext || ext_rdy) begin
                    m_done = 1; e_dtack_n = 0;
                end
            end
        end
        #1;
        check("cs", cs, e_cs);
        check("dtack_n", dtack_n, e_dtack_n);
        check("berr_n", berr_n, e_berr_n);
        check("miss", miss, e_miss);
        if (e_cs != '0) check("cs_idx", cs_idx, e_idx);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_region(input int i, input logic [AW-1:0] b, input logic [AW-1:0] mk,
                              input logic [1:0] md, input logic [WW-1:0] w, input logic x);
        region_en[i]            = 1'b1;
        region_base[i*AW +: AW] = b;
        region_mask[i*AW +: AW] = mk;
        region_mode[2*i +: 2]   = md;
        region_wait[i*WW +: WW] = w;
        region_ext[i]           = x;
    endtask

    initial begin
        reset = 1; m68k_as_n = 1; m68k_rw = 1; m68k_a = '0; ext_rdy = 0;
        region_en = '0; region_ext = '0; region_base = '0; region_mask = '0;
        region_mode = '0; region_wait = '0;
        step(3);
        check("rst cs", cs, 16'h0000);
        check("rst cs_idx", cs_idx, 5'd0);
        check("rst dtack_n", dtack_n, 1'b1);
        check("rst berr_n", berr_n, 1'b1);
        check("rst miss", miss, 1'b0);

        set_region(0, 24'h000000, 24'hFC0000, 2'b00, 4'd0, 1'b0);
        set_region(3, 24'h100000, 24'hFF0000, 2'b00, 4'd3, 1'b0);
        set_region(5, 24'h100000, 24'hF00000, 2'b00, 4'd0, 1'b0);
        set_region(6, 24'h080000, 24'hFF0000, 2'b01, 4'd0, 1'b0);
        set_region(7, 24'h200000, 24'hFF0000, 2'b00, 4'd0, 1'b1);
        reset = 0;
        step(2);

        // Zero-wait read in window 0
        m68k_a = 24'h012344; m68k_rw = 1; m68k_as_n = 0;
        step(1);
        check("t1 cs", cs, 16'h0001);
        check("t1 dtack early", dtack_n, 1'b1);
        step(1);
        check("t1 dtack", dtack_n, 1'b0);
        step(2);
        m68k_as_n = 1;
        step(1);
        check("t1 cs release", cs, 16'h0000);
        check("t1 dtack release", dtack_n, 1'b1);

        // Overlapping windows 3/5, three waits, address/rw wiggle mid-cycle
        step(1);
        m68k_a = 24'h100010; m68k_as_n = 0;
        step(1);
        check("t2 cs", cs, 16'h0008);
        check("t2 cs_idx", cs_idx, 5'd3);
        m68k_a = 24'h012344; m68k_rw = 0;
        step(3);
        check("t2 dtack +4", dtack_n, 1'b1);
        step(1);
        check("t2 dtack +5", dtack_n, 1'b0);
        check("t2 cs held", cs, 16'h0008);
        m68k_rw = 1; m68k_as_n = 1;
        step(2);

        // Write into read-only window 6 -> miss
        m68k_a = 24'h080100; m68k_rw = 0; m68k_as_n = 0;
        step(1);
        check("t3 miss", miss, 1'b1);
        check("t3 cs", cs, 16'h0000);
        step(1);
        check("t3 miss pulse", miss, 1'b0);
        if (TIMEOUT_EN) begin
            step(253);
            check("t3 berr before", berr_n, 1'b1);
            step(1);
            check("t3 berr", berr_n, 1'b0);
            check("t3 no dtack", dtack_n, 1'b1);
        end else begin
            check("t3 miss dtack", dtack_n, 1'b0);
            check("t3 berr tied", berr_n, 1'b1);
        end
        m68k_as_n = 1; m68k_rw = 1;
        step(2);

        // External-ready window 7
        m68k_a = 24'h200000; ext_rdy = 0; m68k_as_n = 0;
        step(10);
        check("t4 dtack waiting", dtack_n, 1'b1);
        check("t4 cs", cs, 16'h0080);
        ext_rdy = 1;
        step(1);
        check("t4 dtack", dtack_n, 1'b0);
        m68k_as_n = 1; ext_rdy = 0;
        step(2);

        // Abort while waiting on ext_rdy
        m68k_as_n = 0;
        step(3);
        check("t4b cs", cs, 16'h0080);
        m68k_as_n = 1;
        step(1);
        check("t4b cs abort", cs, 16'h0000);
        check("t4b dtack abort", dtack_n, 1'b1);
        step(2);
        check("t4b no late dtack", dtack_n, 1'b1);

        // Reset during ACK with strobe still low
        m68k_a = 24'h012344; m68k_as_n = 0;
        step(2);
        check("t5 dtack", dtack_n, 1'b0);
        reset = 1;
        step(1);
        check("t5 cs reset", cs, 16'h0000);
        check("t5 dtack reset", dtack_n, 1'b1);
        reset = 0;
        step(3);
        check("t5 no restart", cs, 16'h0000);
        m68k_as_n = 1;
        step(1);
        m68k_as_n = 0;
        step(1);
        check("t5 restart cs", cs, 16'h0001);
        step(1);
        m68k_as_n = 1;
        step(2);

        // Back-to-back with one sampled high clock between cycles
        m68k_as_n = 0;
        step(2);
        check("t6 dtack a", dtack_n, 1'b0);
        m68k_as_n = 1;
        step(1);
        check("t6 gap cs", cs, 16'h0000);
        check("t6 gap dtack", dtack_n, 1'b1);
        m68k_a = 24'h080010; m68k_rw = 1; m68k_as_n = 0;
        step(1);
        check("t6 cs b", cs, 16'h0040);
        check("t6 cs_idx b", cs_idx, 5'd6);
        step(1);
        check("t6 dtack b", dtack_n, 1'b0);
        m68k_as_n = 1;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
